// File: rtl/if_id_fetch.sv
// Instruction fetch stage and IF/ID pipeline register.
// Redirect from EX outranks a load-use stall; both update all state on the rising clk edge.
module if_id_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_stop,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic [31:0] imem_inst,
  output logic [31:0] imem_addr,
  output logic        id_have_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    OP_NORMAL,
    OP_STALL,
    OP_REDIRECT
  } fetch_op_e;

  fetch_op_e   op;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;

  assign imem_addr   = pc;
  assign pc_next_seq = pc + PC_STEP;

  // Redirect wins over stall: the EX instruction is older than the stalled one.
  always_comb begin
    op = OP_NORMAL;
    if (ex_redirect)        op = OP_REDIRECT;
    else if (pipeline_stop) op = OP_STALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      id_have_inst <= 1'b0;
      id_pc        <= '0;
      id_pc4       <= '0;
      id_inst      <= '0;
      fetch_count  <= '0;
      flush_count  <= '0;
    end else begin
      unique case (op)
        OP_REDIRECT: begin
          pc           <= ex_redirect_pc;
          id_have_inst <= 1'b0;
          if (id_have_inst && (flush_count != '1))
            flush_count <= flush_count + 16'd1;
        end
        OP_STALL: begin
        end
        default: begin
          pc           <= pc_next_seq;
          id_pc        <= pc;
          id_pc4       <= pc_next_seq;
          id_inst      <= imem_inst;
          id_have_inst <= 1'b1;
          fetch_count  <= fetch_count + 32'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed self-checking bench for if_id_fetch with a combinational instruction memory model.
module tb_if_id_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_stop;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic [31:0] imem_inst;
  logic [31:0] imem_addr;
  logic        id_have_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
  logic        use_pattern;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  if_id_fetch #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipeline_stop (pipeline_stop),
    .ex_redirect   (ex_redirect),
    .ex_redirect_pc(ex_redirect_pc),
    .imem_inst     (imem_inst),
    .imem_addr     (imem_addr),
    .id_have_inst  (id_have_inst),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .id_inst       (id_inst),
    .fetch_count   (fetch_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  // Either a constant NOP or an address-dependent word so id_inst is traceable.
  assign imem_inst = use_pattern ? (imem_addr ^ 32'hDEAD_0000) : 32'h0000_0013;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic have, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [31:0] fc, input logic [15:0] flc);
    check({tag, "_have"}, {31'd0, id_have_inst}, {31'd0, have});
    check({tag, "_pc"},   id_pc, pc);
    check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_fcnt"}, fetch_count, fc);
    check({tag, "_flcnt"}, {16'd0, flush_count}, {16'd0, flc});
  endtask

  task automatic check_reset(input string tag);
    check_id(tag, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0);
    check({tag, "_pc4"},  id_pc4, 32'h0);
    check({tag, "_inst"}, id_inst, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    pipeline_stop = 1'b0;
    ex_redirect = 1'b0;
    ex_redirect_pc = '0;
    use_pattern = 1'b0;
    #2;
    check_reset("rst_init");
    // Inputs toggling during reset must have no effect.
    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0500;
    step();
    check_reset("rst_hold");
    ex_redirect = 1'b0;
    rst = 1'b0;

    step(); check_id("free1", 1'b1, 32'h0, 32'h4, 32'd1, 16'd0);
    step(); check_id("free2", 1'b1, 32'h4, 32'h8, 32'd2, 16'd0);
    step(); check_id("free3", 1'b1, 32'h8, 32'hC, 32'd3, 16'd0);
    check("free3_pc4",  id_pc4,  32'hC);
    check("free3_inst", id_inst, 32'h0000_0013);

    pipeline_stop = 1'b1;
    step(); check_id("stall1", 1'b1, 32'h8, 32'hC, 32'd3, 16'd0);
    step(); check_id("stall2", 1'b1, 32'h8, 32'hC, 32'd3, 16'd0);
    pipeline_stop = 1'b0;
    use_pattern = 1'b1;
    step(); check_id("unstall", 1'b1, 32'hC, 32'h10, 32'd4, 16'd0);
    check("unstall_inst", id_inst, 32'hDEAD_000C);

    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0100;
    step(); check_id("redir", 1'b0, 32'hC, 32'h100, 32'd4, 16'd1);
    check("redir_inst_hold", id_inst, 32'hDEAD_000C);
    ex_redirect = 1'b0;
    step(); check_id("redir_tgt", 1'b1, 32'h100, 32'h104, 32'd5, 16'd1);
    check("redir_tgt_pc4", id_pc4, 32'h104);

    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0040; pipeline_stop = 1'b1;
    step(); check_id("prio", 1'b0, 32'h100, 32'h40, 32'd5, 16'd2);
    // Redirect with an empty ID slot must not bump flush_count.
    ex_redirect_pc = 32'hFFFF_FFFC;
    step(); check_id("redir_empty", 1'b0, 32'h100, 32'hFFFF_FFFC, 32'd5, 16'd2);
    ex_redirect = 1'b0; pipeline_stop = 1'b0;
    step(); check_id("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'd6, 16'd2);
    check("wrap_pc4",  id_pc4,  32'h0);
    check("wrap_inst", id_inst, 32'h2152_FFFC);
    step(); check_id("post_wrap", 1'b1, 32'h0, 32'h4, 32'd7, 16'd2);

    pipeline_stop = 1'b1;
    step(); check_id("pre_rst_stall", 1'b1, 32'h0, 32'h4, 32'd7, 16'd2);
    #3 rst = 1'b1;
    #1 check_reset("rst_async");
    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0300;
    step(); check_reset("rst_async_hold");
    ex_redirect = 1'b0; pipeline_stop = 1'b0;
    rst = 1'b0;
    step(); check_id("rst_release", 1'b1, 32'h0, 32'h4, 32'd1, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
